// File: rtl/regfile_wb_queue.sv
// Writeback queue: merges load and ALU writebacks into an in-order FIFO that retires one entry per cycle to reg_file.
// Optional pending-value lookup for rs1/rs2 is enabled by defining WB_BYPASS_EN.
module regfile_wb_queue #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [4:0]       ld_rd,
  input  logic [31:0]      ld_data,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  output logic             we,
  output logic [4:0]       rd,
  output logic [31:0]      wd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             byp1_hit,
  output logic             byp2_hit,
  output logic [31:0]      byp1_data,
  output logic [31:0]      byp2_data,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];

  logic             w_empty;
  logic             w_pop;
  logic [PTR_W+1:0] w_free;
  logic             w_ld_live;
  logic             w_ld_enq;
  logic             w_alu_enq;
  logic [PTR_W:0]   w_enq_n;
  logic [PTR_W-1:0] w_alu_slot;

  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty;

  // The head retires at this edge, so its slot is already reusable.
  assign w_free = (PTR_W+2)'(DEPTH) - {1'b0, r_count} + (PTR_W+2)'(w_pop);

  // A load to x0 takes no slot, so it must not steal the last one from the ALU.
  assign w_ld_live = ld_valid && (ld_rd != '0);
  assign ld_ready  = (w_free != '0);
  assign alu_ready = (w_free >= (PTR_W+2)'(2)) || !w_ld_live;

  assign w_ld_enq   = rst_n && ld_valid  && ld_ready  && (ld_rd  != '0);
  assign w_alu_enq  = rst_n && alu_valid && alu_ready && (alu_rd != '0);
  assign w_enq_n    = (PTR_W+1)'(w_ld_enq) + (PTR_W+1)'(w_alu_enq);
  assign w_alu_slot = r_tail + PTR_W'(w_ld_enq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= r_tail + PTR_W'(w_enq_n);
      r_count <= r_count + w_enq_n - (PTR_W+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_enq) begin
      r_rd[r_tail]   <= ld_rd;
      r_data[r_tail] <= ld_data;
    end
    if (w_alu_enq) begin
      r_rd[w_alu_slot]   <= alu_rd;
      r_data[w_alu_slot] <= alu_data;
    end
  end

  assign we    = w_pop;
  assign rd    = w_empty ? '0 : r_rd[r_head];
  assign wd    = w_empty ? '0 : r_data[r_head];
  assign count = r_count;
  assign empty = w_empty;
  assign full  = (r_count == (PTR_W+1)'(DEPTH));

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] w_idx;

  // Walk oldest to newest so the last match seen is the newest pending value.
  always_comb begin
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = '0;
    byp2_data = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if ((PTR_W+1)'(i) < r_count) begin
        if ((rs1 != '0) && (r_rd[w_idx] == rs1)) begin
          byp1_hit  = 1'b1;
          byp1_data = r_data[w_idx];
        end
        if ((rs2 != '0) && (r_rd[w_idx] == rs2)) begin
          byp2_hit  = 1'b1;
          byp2_data = r_data[w_idx];
        end
      end
    end
  end
`else
  logic w_unused_rs;

  assign w_unused_rs = ^{rs1, rs2};
  assign byp1_hit    = 1'b0;
  assign byp2_hit    = 1'b0;
  assign byp1_data   = '0;
  assign byp2_data   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue (DEPTH=4); bypass expectations follow WB_BYPASS_EN.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        ld_valid, ld_ready, alu_valid, alu_ready;
  logic [4:0]  ld_rd, alu_rd, rd, rs1, rs2;
  logic [31:0] ld_data, alu_data, wd, byp1_data, byp2_data;
  logic        we, byp1_hit, byp2_hit, full, empty;
  logic [2:0]  count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          mcount = 0;
  logic [31:0] shadow [32];
  logic        s_ld_ready, s_alu_ready, m_ld_rdy, m_alu_rdy;
  logic [2:0]  s_count;
  int          s_mcount;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .we(we), .rd(rd), .wd(wd),
    .rs1(rs1), .rs2(rs2),
    .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data),
    .count(count), .full(full), .empty(empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Every write presented to reg_file must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (rst_n === 1'b1 && we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL drain_unexpected: rd=%0d wd=%h, required no write", rd, wd);
      end else begin
        e = sb.pop_front();
        if (rd !== e.rd || wd !== e.data) begin
          failures++;
          $display("FAIL drain_order: rd=%0d wd=%h, required rd=%0d wd=%h", rd, wd, e.rd, e.data);
        end
      end
      shadow[rd] = wd;
    end
  end

  task automatic step(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic av, input logic [4:0] ard, input logic [31:0] adat);
    int   free;
    logic la, aa;
    ld_valid = lv;  ld_rd = lrd;  ld_data = ldat;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    @(negedge clk);
    s_ld_ready  = ld_ready;
    s_alu_ready = alu_ready;
    s_count     = count;
    s_mcount    = mcount;
    free      = DEPTH - mcount + ((mcount != 0) ? 1 : 0);
    m_ld_rdy  = (free >= 1);
    m_alu_rdy = (free >= 2) || !(lv && lrd != 5'd0);
    la = rst_n && lv && m_ld_rdy && (lrd != 5'd0);
    aa = rst_n && av && m_alu_rdy && (ard != 5'd0);
    @(posedge clk);
    if (!rst_n) begin
      mcount = 0;
      sb.delete();
    end else begin
      if (la) sb.push_back('{lrd, ldat});
      if (aa) sb.push_back('{ard, adat});
      mcount = mcount + int'(la) + int'(aa) - ((mcount != 0) ? 1 : 0);
    end
    #1;
    ld_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && mcount != 0; i++) idle();
    checks++;
    if (empty !== 1'b1 || sb.size() != 0 || mcount != 0) begin
      failures++;
      $display("FAIL %s_drain: empty=%b pending=%0d, required empty=1 pending=0", tag, empty, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222);
    step(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222);
    rst_n = 1'b1;
    rs1 = 5'd1; rs2 = 5'd2;
    #1;
    checks++;
    if (we !== 1'b0 || rd !== 5'd0 || wd !== 32'd0) begin
      failures++;
      $display("FAIL reset_port: we=%b rd=%0d wd=%h, required 0 0 0", we, rd, wd);
    end
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b, required 0 1 0", count, empty, full);
    end
    checks++;
    if (ld_ready !== 1'b1 || alu_ready !== 1'b1 || byp1_hit !== 1'b0 || byp2_hit !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_hit: ldr=%b alur=%b h1=%b h2=%b, required 1 1 0 0",
               ld_ready, alu_ready, byp1_hit, byp2_hit);
    end
    idle();
    checks++;
    if (count !== 3'd0 || we !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_entries: count=%0d we=%b, required 0 0", count, we);
    end
  endtask

  task automatic test_single_write();
    step(1'b1, 5'd1, 32'hAAAA_AAAA, 1'b0, 5'd0, 32'd0);
    checks++;
    if (we !== 1'b1 || rd !== 5'd1 || wd !== 32'hAAAA_AAAA || count !== 3'd1) begin
      failures++;
      $display("FAIL single_latency: we=%b rd=%0d wd=%h count=%0d, required 1 1 aaaaaaaa 1", we, rd, wd, count);
    end
    idle();
    checks++;
    if (empty !== 1'b1 || shadow[1] !== 32'hAAAA_AAAA) begin
      failures++;
      $display("FAIL single_readback: empty=%b x1=%h, required 1 aaaaaaaa", empty, shadow[1]);
    end
  endtask

  task automatic test_dual_order();
    step(1'b1, 5'd2, 32'h5555_5555, 1'b1, 5'd2, 32'h1234_5678);
    checks++;
    if (count !== 3'd2) begin
      failures++;
      $display("FAIL dual_count: count=%0d, required 2", count);
    end
    drain("dual");
    checks++;
    if (shadow[2] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL dual_final_x2: x2=%h, required 12345678", shadow[2]);
    end
  endtask

  task automatic test_full_backpressure();
    bit saw_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 5'(1 + i), 32'hA000_0000 + 32'(i), 1'b1, 5'(16 + i), 32'hB000_0000 + 32'(i));
      checks++;
      if (s_count !== 3'(s_mcount) || s_ld_ready !== m_ld_rdy || s_alu_ready !== m_alu_rdy) begin
        failures++;
        $display("FAIL full_ready[%0d]: count=%0d ldr=%b alur=%b, required %0d %b %b",
                 i, s_count, s_ld_ready, s_alu_ready, s_mcount, m_ld_rdy, m_alu_rdy);
      end
      if (s_mcount == DEPTH) begin
        saw_full = 1'b1;
        checks++;
        if (s_alu_ready !== 1'b0 || s_ld_ready !== 1'b1 || full !== 1'b1) begin
          failures++;
          $display("FAIL full_priority[%0d]: ldr=%b alur=%b full=%b, required 1 0 1",
                   i, s_ld_ready, s_alu_ready, full);
        end
      end
    end
    checks++;
    if (!saw_full) begin
      failures++;
      $display("FAIL full_reached: max count not %0d, required %0d", DEPTH, DEPTH);
    end
    drain("full");
  endtask

  task automatic test_x0_drop();
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    checks++;
    if (s_alu_ready !== 1'b1 || count !== 3'd0 || we !== 1'b0) begin
      failures++;
      $display("FAIL x0_alu: alur=%b count=%0d we=%b, required 1 0 0", s_alu_ready, count, we);
    end
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'(4 + i), 32'hC000_0000 + 32'(i), 1'b1, 5'(8 + i), 32'hD000_0000 + 32'(i));
    step(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd5, 32'h0000_0555);
    checks++;
    if (s_count !== 3'd4 || s_alu_ready !== 1'b1 || count !== 3'd4) begin
      failures++;
      $display("FAIL x0_ld_no_slot: count=%0d alur=%b after=%0d, required 4 1 4", s_count, s_alu_ready, count);
    end
    drain("x0");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 5'(10 + i), 32'hE000_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
      checks++;
      if (count !== 3'd1 || we !== 1'b1 || rd !== 5'(10 + i)) begin
        failures++;
        $display("FAIL b2b[%0d]: count=%0d we=%b rd=%0d, required 1 1 %0d", i, count, we, rd, 10 + i);
      end
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid_drain();
    step(1'b1, 5'd20, 32'h0000_0020, 1'b1, 5'd21, 32'h0000_0021);
    step(1'b1, 5'd22, 32'h0000_0022, 1'b1, 5'd23, 32'h0000_0023);
    rst_n = 1'b0;
    step(1'b1, 5'd24, 32'h0000_0024, 1'b1, 5'd25, 32'h0000_0025);
    rst_n = 1'b1;
    checks++;
    if (count !== 3'd0 || we !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_drain: count=%0d we=%b empty=%b, required 0 0 1", count, we, empty);
    end
    idle();
  endtask

  task automatic test_bypass();
    step(1'b1, 5'd3, 32'h0000_0011, 1'b1, 5'd3, 32'h0000_0022);
    rs1 = 5'd3; rs2 = 5'd0;
    #1;
    checks++;
    if (byp1_hit !== BYP || byp1_data !== (BYP ? 32'h22 : 32'h0) || byp2_hit !== 1'b0) begin
      failures++;
      $display("FAIL byp_newest: h1=%b d1=%h h2=%b, required %b %h 0",
               byp1_hit, byp1_data, byp2_hit, BYP, BYP ? 32'h22 : 32'h0);
    end
    idle();
    rs1 = 5'd7; rs2 = 5'd3;
    #1;
    checks++;
    if (byp1_hit !== 1'b0 || byp2_hit !== BYP || byp2_data !== (BYP ? 32'h22 : 32'h0)) begin
      failures++;
      $display("FAIL byp_head: h1=%b h2=%b d2=%h, required 0 %b %h",
               byp1_hit, byp2_hit, byp2_data, BYP, BYP ? 32'h22 : 32'h0);
    end
    drain("byp");
    checks++;
    if (byp2_hit !== 1'b0) begin
      failures++;
      $display("FAIL byp_empty: h2=%b, required 0", byp2_hit);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    rs1 = '0; rs2 = '0;
    test_reset();
    test_single_write();
    test_dual_order();
    test_full_backpressure();
    test_x0_drop();
    test_back_to_back();
    test_reset_mid_drain();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback queue sitting between the execute/load stages and the write port of `reg_file`. It accepts up to two writeback requests per cycle (load unit and ALU) over valid/ready handshakes, buffers them in a small in-order FIFO, and retires exactly one entry per cycle onto the single `we`/`rd`/`wd` port of `reg_file`. Writes to x0 are dropped at entry. An optional bypass lookup lets the decode stage read still-pending values for `rs1`/`rs2`.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, 2..16.
- `PTR_W`, $clog2(DEPTH): pointer width (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `ld_valid`  in  1  load writeback request.
- `ld_ready`  out  1  load request accepted this cycle when high with `ld_valid`.
- `ld_rd`  in  5  load destination register.
- `ld_data`  in  32  load result.
- `alu_valid`  in  1  ALU writeback request.
- `alu_ready`  out  1  ALU request accepted this cycle when high with `alu_valid`.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `we`  out  1  to `reg_file.we`.
- `rd`  out  5  to `reg_file.rd`.
- `wd`  out  32  to `reg_file.wd`.
- `rs1`, `rs2`  in  5 each  bypass lookup addresses.
- `byp1_hit`, `byp2_hit`  out  1 each  pending value exists for `rs1`/`rs2`.
- `byp1_data`, `byp2_data`  out  32 each  newest pending value.
- `count`  out  PTR_W+1  occupied entries.
- `full`, `empty`  out  1 each  `count==DEPTH` / `count==0`.

## Operation
- Storage: DEPTH entries of {rd[4:0], data[31:0]}, head/tail pointers of PTR_W bits wrapping modulo DEPTH, plus registered `count`.
- Drain: whenever `!empty`, head entry drives `we=1`, `rd`, `wd`; head pops at the same edge `reg_file` captures. `we=0`, `rd=0`, `wd=0` when empty.
- Free slots this cycle: `free = DEPTH - count + (empty ? 0 : 1)`.
- `ld_ready = (free >= 1)`; `alu_ready = (free >= 2) || (free >= 1 && !ld_valid)`. Load has priority on the last slot.
- Ordering: load is older; when both accepted in one cycle, load entry written at tail, ALU entry at tail+1.
- x0: a request with rd==0 still handshakes (ready as above) but is not enqueued and consumes no slot; `free` accounting ignores it when computing the other source's ready.
- `count_next = count + enq_count - (empty ? 0 : 1)`; never exceeds DEPTH, never underflows.
- Reset (`rst_n==0` at edge): head=tail=0, count=0; all queued entries discarded, including mid-drain. Outputs after reset: `we=0`, `rd=0`, `wd=0`, `empty=1`, `full=0`, `count=0`, both readys high, both hits 0. Requests presented in a reset cycle are not accepted.

## Timing
- Enqueue-to-write latency: 1 cycle minimum (entry accepted at edge N is on `we/rd/wd` during cycle N+1, written at edge N+1) when queue empty; otherwise behind older entries, one per cycle.
- `we/rd/wd`, `full`, `empty`, `count` are functions of registered state only.
- Readys depend on registered state and `ld_valid` (rd is handled too); no path from `alu_valid` to any ready.
- Throughput: one retire per cycle sustained; burst of two enqueues per cycle absorbed until full.
- Bypass is combinational from registered queue contents and `rs1`/`rs2`; requests being enqueued this cycle are not visible until the next cycle.

## Configuration
- `WB_BYPASS_EN` defined: per port, search all valid entries; hit when an entry's rd equals the lookup address and address != 0; data from the newest (closest to tail) match. The head entry being written this cycle still counts as a hit.
- Not defined: `byp*_hit=0`, `byp*_data=0`, `rs1`/`rs2` unused, no search logic synthesized.

## Test plan
- Reset: hold `rst_n=0` 2 cycles with both valids high -> `we=0`, `count=0`, no entries after release.
- Single write: ld rd=1 data=0xAAAA_AAAA at edge N -> cycle N+1 `we=1 rd=1 wd=0xAAAA_AAAA`, then empty; reg_file readback rs1=1 gives 0xAAAA_AAAA.
- Dual enqueue ordering: ld rd=2 0x5555_5555 and alu rd=2 0x1234_5678 same cycle -> drains ld then alu; final x2=0x1234_5678.
- Full/back-pressure (DEPTH=4): both valid every cycle -> count reaches 4; with free==1 and ld_valid, `alu_ready=0`, `ld_ready=1`; no entry lost, order preserved through pointer wrap.
- x0 drop: alu rd=0 data=0xDEAD_BEEF -> `alu_ready=1`, count unchanged, `we` never asserted with rd=0.
- Bypass (`WB_BYPASS_EN`): queue holds rd=3 0x11, then rd=3 0x22 -> rs1=3 gives hit=1 data=0x22; rs2=0 gives hit=0; macro undefined -> hits always 0.
